// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O responder at FFF0-FFFE.
// Debounces KEY/SW, latches key-press edges, drives HEX/LEDR/LEDG and runs a tick timer.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   ADDR, DIN, WE     processor data-memory address, write data, write strobe
//   DOUT, SEL         read data (combinational), I/O range select
//   KEY, SW           raw push-buttons (active-low) and slide switches
//   HEXVAL, LEDR, LEDG  output registers for the board displays
module io_responder #(
    parameter int DBITS           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 50000,
    parameter int CNTBITS         = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEXVAL,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    // Keys occupy bits [3:0], switches bits [13:4] of the shared input path.
    localparam int NIN = 14;
    localparam logic [CNTBITS-1:0] DEB_LAST  = CNTBITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTBITS-1:0] TICK_LAST = CNTBITS'(TICK_CYCLES - 1);

    logic [NIN-1:0]     raw;
    logic [NIN-1:0]     s1_q;
    logic [NIN-1:0]     s2_q;
    logic [NIN-1:0]     deb_q;
    logic [NIN-1:0]     deb_d;
    logic [CNTBITS-1:0] cnt_q [NIN];
    logic [CNTBITS-1:0] cnt_d [NIN];

    logic [3:0]         kedge_q;
    logic [3:0]         kedge_d;
    logic [3:0]         key_rise;
    logic [DBITS-1:0]   timer_q;
    logic [DBITS-1:0]   timer_d;
    logic [CNTBITS-1:0] presc_q;
    logic [CNTBITS-1:0] presc_d;
    logic [15:0]        hex_q;
    logic [15:0]        hex_d;
    logic [9:0]         ledr_q;
    logic [9:0]         ledr_d;
    logic [7:0]         ledg_q;
    logic [7:0]         ledg_d;

    logic               wr_en;
    logic [2:0]         reg_idx;
    logic               unused_addr0;

    // Keys are inverted before synchronising so that 0 means released
    // everywhere, including the reset value of the sync flops.
    assign raw     = {SW, ~KEY};
    assign SEL     = &ADDR[DBITS-1:4];
    assign reg_idx = ADDR[3:1];
    assign wr_en   = WE & SEL;

    assign unused_addr0 = ADDR[0];

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNTBITS'(1);
                end
            end
        end
    end

    // Edge detect off the next debounced level so the flag lands on
    // the same edge as the level, letting set win over a W1C clear.
    assign key_rise = deb_d[3:0] & ~deb_q[3:0];

    always_comb begin
        kedge_d = kedge_q;
        timer_d = timer_q;
        presc_d = presc_q;
        hex_d   = hex_q;
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;

        if (presc_q == TICK_LAST) begin
            presc_d = '0;
            timer_d = timer_q + DBITS'(1);
        end else begin
            presc_d = presc_q + CNTBITS'(1);
        end

        if (wr_en) begin
            case (reg_idx)
                3'd2: kedge_d = kedge_q & ~DIN[3:0];
                3'd3: begin
                    timer_d = DIN;
                    presc_d = '0;
                end
                3'd4: hex_d  = DIN[15:0];
                3'd5: ledr_d = DIN[9:0];
                3'd6: ledg_d = DIN[7:0];
                default: ;
            endcase
        end

        kedge_d = kedge_d | key_rise;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= '0;
            end
            kedge_q <= '0;
            timer_q <= '0;
            presc_q <= '0;
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            kedge_q <= kedge_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
            hex_q   <= hex_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
        end
    end

    always_comb begin
        DOUT = DBITS'(16'hDEAD);
        if (SEL) begin
            case (reg_idx)
                3'd0: DOUT = DBITS'(deb_q[3:0]);
                3'd1: DOUT = DBITS'(deb_q[13:4]);
                3'd2: DOUT = DBITS'(kedge_q);
                3'd3: DOUT = timer_q;
                3'd4: DOUT = DBITS'(hex_q);
                3'd5: DOUT = DBITS'(ledr_q);
                3'd6: DOUT = DBITS'(ledg_q);
                default: DOUT = DBITS'(16'hDEAD);
            endcase
        end
    end

    assign HEXVAL = hex_q;
    assign LEDR   = ledr_q;
    assign LEDG   = ledg_q;

endmodule
